// File: rtl/button_event_sched.sv
// button_event_sched: sync+debounce btn_i into st_o, one-deep edge slot per channel, round-robin serve on ev_valid/ev_ready/ev_id/ev_up, sticky ovf_o cleared by ovf_clr
module button_event_sched #(
  parameter int N = 4,
  parameter int STABLE = 3,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   btn_i,
  output logic [N-1:0]   st_o,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [IDW-1:0] ev_id,
  output logic           ev_up,
  output logic [N-1:0]   ovf_o,
  input  logic           ovf_clr
);
  localparam int CW = $clog2(STABLE + 1);
  logic [N-1:0] s1, s, gen, slot_v, slot_t, cons, ovf_set;
  logic [CW-1:0] cnt [N];
  logic [IDW-1:0] ptr, gnt, j;
  logic any, load;
  always_comb begin
    load = !ev_valid || ev_ready;
    gnt = '0;
    any = 1'b0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = IDW'((int'(ptr) + i) % N);
      if (slot_v[j]) begin
        gnt = j;
        any = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      gen[k] = (s[k] != st_o[k]) && (cnt[k] == CW'(STABLE - 1));
      cons[k] = load && any && (int'(gnt) == k);
      ovf_set[k] = gen[k] && slot_v[k] && !cons[k];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s <= '0;
      st_o <= '0;
      slot_v <= '0;
      slot_t <= '0;
      ovf_o <= '0;
      ev_valid <= 1'b0;
      ev_id <= '0;
      ev_up <= 1'b0;
      ptr <= IDW'(N - 1);
      for (int k = 0; k < N; k++) cnt[k] <= '0;
    end else begin
      s1 <= btn_i;
      s <= s1;
      for (int k = 0; k < N; k++) cnt[k] <= (s[k] == st_o[k] || gen[k]) ? '0 : cnt[k] + 1'b1;
      st_o <= (st_o & ~gen) | (s & gen);
      slot_v <= gen | (slot_v & ~cons);
      slot_t <= (slot_t & ~gen) | (s & gen);
      ovf_o <= (ovf_clr ? '0 : ovf_o) | ovf_set;
      if (load) begin
        ev_valid <= any;
        if (any) begin
          ev_id <= gnt;
          ev_up <= slot_t[gnt];
          ptr <= gnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_button_event_sched.sv
// tb_button_event_sched: randomized and directed checks of button_event_sched against a window/queue reference model
module tb_button_event_sched;
  localparam int N = 4;
  localparam int STABLE = 3;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ev_ready = 1'b0;
  logic ovf_clr = 1'b0;
  logic [N-1:0] btn_i = '0;
  logic [N-1:0] st_o, ovf_o;
  logic ev_valid, ev_up;
  logic [IDW-1:0] ev_id;
  int checks = 0;
  int errors = 0;
  bit [N-1:0] m_st, m_sv, m_sty, m_ovf;
  bit m_v, m_up;
  bit [IDW-1:0] m_id;
  int m_ptr;
  bit hist [N][STABLE+1];
  always #5 clk = ~clk;
  button_event_sched #(.N(N), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .btn_i(btn_i), .st_o(st_o), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_id(ev_id), .ev_up(ev_up), .ovf_o(ovf_o), .ovf_clr(ovf_clr)
  );
  function automatic logic [11:0] dut_vec();
    return {ev_valid, ev_id, ev_up, st_o, ovf_o};
  endfunction
  function automatic logic [11:0] exp_vec();
    return {m_v, m_id, m_up, m_st, m_ovf};
  endfunction
  task automatic model_reset();
    m_st = '0; m_sv = '0; m_sty = '0; m_ovf = '0;
    m_v = 1'b0; m_up = 1'b0; m_id = '0; m_ptr = N - 1;
    for (int k = 0; k < N; k++) for (int i = 0; i <= STABLE; i++) hist[k][i] = 1'b0;
  endtask
  // hist[k][i] is the raw level seen i+1 edges ago; the synchronized level lags raw by two edges,
  // so a level is accepted once the STABLE synchronized samples feeding this edge all disagree with it.
  task automatic model_step();
    bit [N-1:0] g, nov, cn;
    bit ld;
    int best, bd, d;
    for (int k = 0; k < N; k++) begin
      g[k] = 1'b1;
      for (int i = 1; i <= STABLE; i++) if (hist[k][i] == m_st[k]) g[k] = 1'b0;
    end
    ld = !m_v || ev_ready;
    best = -1;
    bd = N;
    for (int k = 0; k < N; k++) begin
      d = (k - m_ptr - 1 + 2 * N) % N;
      if (m_sv[k] && d < bd) begin bd = d; best = k; end
    end
    cn = '0;
    if (ld && best >= 0) cn[best] = 1'b1;
    nov = ovf_clr ? '0 : m_ovf;
    for (int k = 0; k < N; k++) if (g[k] && m_sv[k] && !cn[k]) nov[k] = 1'b1;
    if (ld) begin
      m_v = (best >= 0);
      if (best >= 0) begin
        m_id = best[IDW-1:0];
        m_up = m_sty[best];
        m_ptr = best;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (cn[k]) m_sv[k] = 1'b0;
      if (g[k]) begin
        m_sv[k] = 1'b1;
        m_st[k] = ~m_st[k];
        m_sty[k] = m_st[k];
      end
      for (int i = STABLE; i >= 1; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = btn_i[k];
    end
    m_ovf = nov;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; btn_i = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_reset();
    int bad;
    rst = 1'b1; btn_i = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 12'h000) begin errors++; $display("FAIL reset_values got=%h want=000", dut_vec()); end
    rst = 1'b0;
    model_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ev_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_no_event got=%0d valid cycles want=0", bad); end
  endtask
  task automatic test_single_press();
    do_reset();
    ev_ready = 1'b1;
    btn_i[2] = 1'b1;
    repeat (5) tick();
    checks++;
    if ({st_o, ev_valid} !== {4'b0100, 1'b0}) begin errors++; $display("FAIL press_st got st=%b v=%b want st=0100 v=0", st_o, ev_valid); end
    tick();
    checks++;
    if ({ev_valid, ev_id, ev_up} !== 4'b1101) begin errors++; $display("FAIL press_event got=%b want=1101", {ev_valid, ev_id, ev_up}); end
    tick();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL press_one_cycle got=%b want=0", ev_valid); end
    btn_i[2] = 1'b0;
    repeat (6) tick();
    checks++;
    if ({ev_valid, ev_id, ev_up} !== 4'b1100) begin errors++; $display("FAIL release_event got=%b want=1100", {ev_valid, ev_id, ev_up}); end
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL press_model got=%h want=%h", dut_vec(), exp_vec()); end
  endtask
  task automatic test_glitch();
    bit seen;
    do_reset();
    ev_ready = 1'b1;
    btn_i[0] = 1'b1;
    repeat (2) tick();
    btn_i[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ev_valid || st_o[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch_reject got=%b want=0", seen); end
    btn_i[0] = 1'b1;
    repeat (3) tick();
    btn_i[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ev_valid && ev_id == 2'd0 && ev_up) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL hold3_event got=%b want=1", seen); end
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL glitch_model got=%h want=%h", dut_vec(), exp_vec()); end
  endtask
  task automatic test_round_robin();
    logic [IDW-1:0] ids [3];
    logic ups [3];
    do_reset();
    btn_i = 4'b1011;
    repeat (10) tick();
    ev_ready = 1'b1;
    ids = '{2'd0, 2'd1, 2'd3};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ev_valid, ev_id, ev_up} !== {1'b1, ids[i], 1'b1}) begin errors++; $display("FAIL rr_a%0d got=%b want=%b", i, {ev_valid, ev_id, ev_up}, {1'b1, ids[i], 1'b1}); end
      tick();
    end
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL rr_a_drain got=%b want=0", ev_valid); end
    btn_i = 4'b1001;
    repeat (8) tick();
    ev_ready = 1'b0;
    btn_i = 4'b0010;
    repeat (10) tick();
    ev_ready = 1'b1;
    ids = '{2'd3, 2'd0, 2'd1};
    ups = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ev_valid, ev_id, ev_up} !== {1'b1, ids[i], ups[i]}) begin errors++; $display("FAIL rr_b%0d got=%b want=%b", i, {ev_valid, ev_id, ev_up}, {1'b1, ids[i], ups[i]}); end
      tick();
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL rr_model got=%h want=%h", dut_vec(), exp_vec()); end
  endtask
  task automatic test_overflow();
    do_reset();
    btn_i = 4'b0001;
    repeat (6) tick();
    checks++;
    if ({ev_valid, ev_id, ev_up} !== 4'b1001) begin errors++; $display("FAIL ovf_hold got=%b want=1001", {ev_valid, ev_id, ev_up}); end
    btn_i = 4'b0011;
    repeat (5) tick();
    btn_i = 4'b0001;
    repeat (5) tick();
    checks++;
    if ({ovf_o, st_o} !== {4'b0010, 4'b0001}) begin errors++; $display("FAIL ovf_set got ovf=%b st=%b want ovf=0010 st=0001", ovf_o, st_o); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf_o !== 4'b0000) begin errors++; $display("FAIL ovf_clear got=%b want=0000", ovf_o); end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    checks++;
    if ({ev_valid, ev_id, ev_up} !== 4'b1010) begin errors++; $display("FAIL ovf_slot_type got=%b want=1010", {ev_valid, ev_id, ev_up}); end
    btn_i = 4'b0101;
    repeat (5) tick();
    btn_i = 4'b0001;
    repeat (4) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf_o !== 4'b0100) begin errors++; $display("FAIL ovf_set_wins got=%b want=0100", ovf_o); end
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ovf_model got=%h want=%h", dut_vec(), exp_vec()); end
  endtask
  task automatic test_backpressure();
    int bad;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if ({ev_valid, ev_id, ev_up} !== 4'b1010) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable got=%0d unstable cycles want=0", bad); end
    btn_i = 4'b0101;
    repeat (4) tick();
    ev_ready = 1'b1;
    tick();
    checks++;
    if ({ev_valid, ev_id, ev_up, ovf_o} !== {4'b1100, 4'b0000}) begin errors++; $display("FAIL bp_consume_fill got=%b ovf=%b want=1100 ovf=0000", {ev_valid, ev_id, ev_up}, ovf_o); end
    tick();
    checks++;
    if ({ev_valid, ev_id, ev_up, ovf_o} !== {4'b1101, 4'b0000}) begin errors++; $display("FAIL bp_next_event got=%b ovf=%b want=1101 ovf=0000", {ev_valid, ev_id, ev_up}, ovf_o); end
    tick();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b want=0", ev_valid); end
  endtask
  task automatic test_reset_mid();
    bit seen;
    btn_i = 4'b0100;
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 12'h000) begin errors++; $display("FAIL async_reset got=%h want=000", dut_vec()); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    ev_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ev_valid && ev_id == 2'd2 && ev_up) seen = 1'b1;
    end
    checks++;
    if ({seen, st_o} !== {1'b1, 4'b0100}) begin errors++; $display("FAIL held_through_reset got seen=%b st=%b want seen=1 st=0100", seen, st_o); end
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_mid_model got=%h want=%h", dut_vec(), exp_vec()); end
  endtask
  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 5) == 0) btn_i[k] = ~btn_i[k];
      ev_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random_cycle%0d got=%h want=%h", c, dut_vec(), exp_vec());
        bad++;
      end
    end
    ovf_clr = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_event_sched.md
# button_event_sched

Multi-channel button front end and event scheduler. Synchronizes and debounces N raw button lines. Each clean press or release becomes one event, held in a one-deep per-channel slot. A round-robin arbiter serves the slots to a single consumer (UART reporter, menu FSM) over a valid/ready handshake. It sits between the board's button pins and the control logic, replacing ad-hoc per-button filters.

## Interface
- `N`, 4: number of button channels, 1..16.
- `STABLE`, 3: consecutive mismatching cycles needed to accept a new level, ≥1.
- `IDW`, clog2(N) (1 when N=1): width of `ev_id`.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_i` in N: raw, asynchronous button lines.
- `st_o` out N: debounced level per channel.
- `ev_valid` out 1: event present on `ev_id`/`ev_up`.
- `ev_ready` in 1: consumer accepts event.
- `ev_id` out IDW: channel index of the event.
- `ev_up` out 1: 1 = rising edge (press), 0 = falling edge (release).
- `ovf_o` out N: sticky per-channel overflow, an event was lost.
- `ovf_clr` in 1: clears all `ovf_o` bits.

## Operation
- **Reset values.** `st_o`=0, `ev_valid`=0, `ev_id`=0, `ev_up`=0, `ovf_o`=0. All slots are empty, sync flops are 0, counters are 0, and the round-robin pointer is N-1, so channel 0 has first priority.
- **Synchronizer.** Two flops per channel produce `s[k]`.
- **Debounce counter.** Per channel, width clog2(STABLE+1).
  - If `s[k]==st[k]`, the counter goes to 0.
  - Otherwise it increments.
  - On the edge where `s[k]!=st[k]` and the count is STABLE-1, `st[k]` takes `s[k]`, the counter goes to 0, and an edge event is generated.
  - A glitch shorter than STABLE cycles never changes `st`.
- **Event slot.** Per channel: a valid bit plus an edge type.
  - A generated edge writes the slot: valid=1, type = new `st[k]`.
  - If the slot is already valid and is not being consumed on that same edge, the old event is overwritten and `ovf_o[k]` is set.
  - If the slot is consumed on the same edge, the new event fills the slot and no overflow occurs.
- **Overflow clear.** `ovf_clr` clears `ovf_o`. If a set and `ovf_clr` happen on the same edge, the set wins.
- **Output register load.** The register loads when `ev_valid`=0, or when `ev_valid`=1 and `ev_ready`=1.
  - The arbiter picks the first valid slot, searching from pointer+1 modulo N.
  - The loaded slot is cleared and the pointer takes the granted index.
  - If no slot is valid, `ev_valid` goes to 0 on the handshake.
- **Output stability.** While `ev_valid`=1 and `ev_ready`=0, `ev_id` and `ev_up` are held stable.
- **Reset mid-operation.** Pending events, counters and overflow flags are discarded. After release, `st_o` re-acquires from 0, so a button held through reset produces a press event.

## Timing
- **Latency.** Raw level changes before edge 1 and holds. Then:
  - `s` updates at edge 2.
  - Mismatch is counted on edges 3..2+STABLE.
  - `st_o` and the slot update at edge 2+STABLE.
  - `ev_valid` rises after edge 3+STABLE (edge 6 for STABLE=3), provided the output register is free and no other slot wins.
- **Throughput.** One event per cycle under continuous `ev_ready`=1, so back-to-back grants are possible.
- **Fairness.** With all N slots valid and `ev_ready`=1, grants rotate k+1, k+2, … The maximum wait for a pending slot is N-1 grants.
- **Handshake.** Transfer occurs on an edge with `ev_valid`&`ev_ready`. `ev_ready` may be asserted regardless of `ev_valid`.
- **Combinational paths.** There is no combinational path from `ev_ready` to `ev_valid`, `ev_id` or `ev_up`. All outputs are registered.

## Test plan
- **Reset and idle.** Assert `rst` mid-cycle → all outputs 0 immediately (asynchronous). Release reset with `btn_i`=0 for 20 cycles → `ev_valid` stays 0.
- **Single press.** N=4, STABLE=3, `ev_ready`=1. Set `btn_i[2]` 0→1 before edge 1 and hold → `st_o[2]`=1 after edge 5; `ev_valid`=1, `ev_id`=2, `ev_up`=1 after edge 6 for one cycle. Release → `ev_up`=0 event.
- **Glitch reject.** Pulse `btn_i[0]` high for 2 cycles (STABLE=3) → `st_o` unchanged, no event. Then hold 3 cycles → event.
- **Round-robin.** `ev_ready`=0. Press channels 0, 1, 3 simultaneously and wait 10 cycles, then set `ev_ready`=1 → ids 0, 1, 3 on consecutive cycles. Repeat with the pointer at 1 → order 3, 0, 1.
- **Overflow.**
  - `ev_ready`=0 while channel 1 presses and channel 0 holds the output register.
  - Release channel 1 after the press is committed → `ovf_o[1]`=1, and the slot holds `ev_up`=0.
  - Pulse `ovf_clr` → `ovf_o`=0.
  - Same-edge set-vs-clear → remains 1.
- **Backpressure.** Hold `ev_ready`=0 for 5 cycles with `ev_valid`=1 → `ev_id`/`ev_up` constant. Simultaneous consume and new edge on the same channel → no overflow, and the next event is delivered.
